// File: rtl/fib_cpu_pkg.sv
// fib_cpu_pkg
// Shared definitions for the Fibonacci/CPU datapath and its control FSM:
// data width and register count defaults, ALU opcode encodings, and the
// bit positions of the five condition flags inside the flag register.
package fib_cpu_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 16;
  localparam int SELW   = 4;
  localparam int NFLAGS = 5;

  // Flag register bit positions
  localparam int FLAG_C = 0;  // carry / borrow
  localparam int FLAG_L = 1;  // unsigned less-than (CMP)
  localparam int FLAG_F = 2;  // signed overflow
  localparam int FLAG_Z = 3;  // zero / equal
  localparam int FLAG_N = 4;  // negative / signed less-than (CMP)

  // ALU opcode encodings; any other 8-bit value is undefined
  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_AND  = 8'h01,
    OP_OR   = 8'h02,
    OP_XOR  = 8'h03,
    OP_ADD  = 8'h05,
    OP_ADDU = 8'h06,
    OP_ADDC = 8'h07,
    OP_SUB  = 8'h09,
    OP_SUBC = 8'h0A,
    OP_CMP  = 8'h0B,
    OP_MOV  = 8'h0D
  } opcode_e;

  // Signed overflow of a 16-bit add: operands share a sign the result lacks.
  function automatic logic addOverflow(input logic aSign, input logic bSign,
                                       input logic rSign);
    return (aSign == bSign) && (rSign != aSign);
  endfunction

  // Signed overflow of a 16-bit subtract a - b: operands differ in sign and
  // the result's sign differs from the minuend.
  function automatic logic subOverflow(input logic aSign, input logic bSign,
                                       input logic rSign);
    return (aSign != bSign) && (rSign != aSign);
  endfunction

endpackage

// File: rtl/fib_datapath_if.sv
// fib_datapath_if
// Bundles the per-cycle control word issued by the control FSM together with
// the datapath's observation outputs.
//   master : control FSM / bench side, drives the control word and rd_sel
//   slave  : datapath side, drives rd_data, flags and illegal_op
// Signals:
//   enableRegs[16]  per-register write enable
//   resRegs[16]     per-register clear (wins over enable)
//   opCode[8]       ALU operation
//   enableFlags[5]  per-flag update enable, bit order C L F Z N
//   muxRsrc[4]      operand B register select
//   muxRdest[4]     operand A register select
//   muxRI           operand B source: 0 register, 1 immediate
//   imm[16]         immediate operand
//   rd_sel[4]       read-port register select
//   rd_data[16]     registered read-port data
//   flags[5]        current flag register
//   illegal_op      one-cycle pulse after an undefined opcode
interface fib_datapath_if;
  import fib_cpu_pkg::*;

  logic [NREGS-1:0]  enableRegs;
  logic [NREGS-1:0]  resRegs;
  logic [7:0]        opCode;
  logic [NFLAGS-1:0] enableFlags;
  logic [SELW-1:0]   muxRsrc;
  logic [SELW-1:0]   muxRdest;
  logic              muxRI;
  logic [WIDTH-1:0]  imm;
  logic [SELW-1:0]   rd_sel;
  logic [WIDTH-1:0]  rd_data;
  logic [NFLAGS-1:0] flags;
  logic              illegal_op;

  modport master (
    output enableRegs, resRegs, opCode, enableFlags,
           muxRsrc, muxRdest, muxRI, imm, rd_sel,
    input  rd_data, flags, illegal_op
  );

  modport slave (
    input  enableRegs, resRegs, opCode, enableFlags,
           muxRsrc, muxRdest, muxRI, imm, rd_sel,
    output rd_data, flags, illegal_op
  );

endinterface

// File: rtl/fib_datapath_alu16.sv
// alu16
// Purely combinational 16-bit ALU for the Fibonacci/CPU datapath.
// Ports:
//   a, b      operand A (destination register) and operand B (source/imm)
//   cin       carry flag as held at the start of the cycle (ADDC/SUBC)
//   opCode    operation select
//   result    operation result
//   writesReg high when the operation is allowed to write registers
//   flagVal   value each flag would take
//   flagDef   mask of the flags this operation defines
//   illegal   high for undefined opcodes
module alu16
  import fib_cpu_pkg::*;
(
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic [7:0]        opCode,
  output logic [WIDTH-1:0]  result,
  output logic              writesReg,
  output logic [NFLAGS-1:0] flagVal,
  output logic [NFLAGS-1:0] flagDef,
  output logic              illegal
);

  logic [WIDTH:0] sum17;
  logic [WIDTH:0] diff17;
  logic           carryIn;

  // Arithmetic is done on 17-bit values so bit 16 gives carry (add) or
  // borrow (subtract) directly. Only ADDC/SUBC consume the carry flag.
  always_comb begin
    carryIn = 1'b0;
    if (opCode == OP_ADDC || opCode == OP_SUBC) begin
      carryIn = cin;
    end
    sum17  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryIn};
    diff17 = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carryIn};
  end

  // Operation decode: result, write permission and the flag set each
  // opcode defines. Unknown opcodes write nothing and raise illegal.
  always_comb begin
    result    = '0;
    writesReg = 1'b0;
    flagVal   = '0;
    flagDef   = '0;
    illegal   = 1'b0;

    case (opCode)
      OP_NOP: begin
      end
      OP_AND, OP_OR, OP_XOR, OP_MOV: begin
        case (opCode)
          OP_AND:  result = a & b;
          OP_OR:   result = a | b;
          OP_XOR:  result = a ^ b;
          default: result = b;
        endcase
        writesReg       = 1'b1;
        flagDef[FLAG_Z] = 1'b1;
        flagDef[FLAG_N] = 1'b1;
        flagVal[FLAG_Z] = (result == '0);
        flagVal[FLAG_N] = result[WIDTH-1];
      end
      OP_ADD, OP_ADDC: begin
        result          = sum17[WIDTH-1:0];
        writesReg       = 1'b1;
        flagDef[FLAG_C] = 1'b1;
        flagDef[FLAG_F] = 1'b1;
        flagDef[FLAG_Z] = 1'b1;
        flagDef[FLAG_N] = 1'b1;
        flagVal[FLAG_C] = sum17[WIDTH];
        flagVal[FLAG_F] = addOverflow(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1]);
        flagVal[FLAG_Z] = (result == '0);
        flagVal[FLAG_N] = result[WIDTH-1];
      end
      OP_ADDU: begin
        result    = sum17[WIDTH-1:0];
        writesReg = 1'b1;
      end
      OP_SUB, OP_SUBC: begin
        result          = diff17[WIDTH-1:0];
        writesReg       = 1'b1;
        flagDef[FLAG_C] = 1'b1;
        flagDef[FLAG_F] = 1'b1;
        flagDef[FLAG_Z] = 1'b1;
        flagDef[FLAG_N] = 1'b1;
        flagVal[FLAG_C] = diff17[WIDTH];
        flagVal[FLAG_F] = subOverflow(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1]);
        flagVal[FLAG_Z] = (result == '0);
        flagVal[FLAG_N] = result[WIDTH-1];
      end
      OP_CMP: begin
        flagDef[FLAG_Z] = 1'b1;
        flagDef[FLAG_L] = 1'b1;
        flagDef[FLAG_N] = 1'b1;
        flagVal[FLAG_Z] = (a == b);
        flagVal[FLAG_L] = (a < b);
        flagVal[FLAG_N] = ($signed(a) < $signed(b));
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fib_datapath.sv
// fib_datapath
// Register file, flag register and registered read port for the
// Fibonacci/CPU. Executes one control word per clock through alu16.
// Ports:
//   clk  rising-edge clock
//   rs   synchronous active-high reset: clears registers, flags, rd_data
//        and illegal_op, overriding the control word
//   bus  slave side of fib_datapath_if (control word in, rd_data / flags /
//        illegal_op out)
module fib_datapath
  import fib_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rs,
  fib_datapath_if.slave bus
);

  logic [WIDTH-1:0]  regFile [NREGS];
  logic [NFLAGS-1:0] flagReg;
  logic [WIDTH-1:0]  rdDataReg;
  logic              illegalReg;

  logic [WIDTH-1:0]  operandA;
  logic [WIDTH-1:0]  operandB;
  logic [WIDTH-1:0]  aluResult;
  logic              aluWrites;
  logic [NFLAGS-1:0] aluFlagVal;
  logic [NFLAGS-1:0] aluFlagDef;
  logic              aluIllegal;

  // Operand selection: A always from a register, B from register or imm
  always_comb begin
    operandA = regFile[bus.muxRdest];
    operandB = bus.muxRI ? bus.imm : regFile[bus.muxRsrc];
  end

  alu16 u_alu (
    .a         (operandA),
    .b         (operandB),
    .cin       (flagReg[FLAG_C]),
    .opCode    (bus.opCode),
    .result    (aluResult),
    .writesReg (aluWrites),
    .flagVal   (aluFlagVal),
    .flagDef   (aluFlagDef),
    .illegal   (aluIllegal)
  );

  // Register file: clear beats write; an undefined opcode changes nothing,
  // so its clears are suppressed as well.
  always_ff @(posedge clk) begin
    if (rs) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile[i] <= '0;
      end
    end else if (!aluIllegal) begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.resRegs[i]) begin
          regFile[i] <= '0;
        end else if (bus.enableRegs[i] && aluWrites) begin
          regFile[i] <= aluResult;
        end
      end
    end
  end

  // Flag register: a flag moves only when enabled and defined by the op
  always_ff @(posedge clk) begin
    if (rs) begin
      flagReg <= '0;
    end else begin
      for (int k = 0; k < NFLAGS; k++) begin
        if (bus.enableFlags[k] && aluFlagDef[k]) begin
          flagReg[k] <= aluFlagVal[k];
        end
      end
    end
  end

  // Read port and illegal pulse; read samples the pre-write register state
  always_ff @(posedge clk) begin
    if (rs) begin
      rdDataReg  <= '0;
      illegalReg <= 1'b0;
    end else begin
      rdDataReg  <= regFile[bus.rd_sel];
      illegalReg <= aluIllegal;
    end
  end

  assign bus.rd_data    = rdDataReg;
  assign bus.flags      = flagReg;
  assign bus.illegal_op = illegalReg;

endmodule

// File: tb/tb_fib_datapath.sv
// tb_fib_datapath
// Directed self-checking bench for fib_datapath.
module tb_fib_datapath;
  import fib_cpu_pkg::*;

  logic clk;
  logic rs;
  int   checks;
  int   failures;

  fib_datapath_if bus ();

  fib_datapath dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one control word for one cycle; sample point is #1 after edge
  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] en,
                               input logic [15:0] res, input logic [4:0] ef,
                               input logic [3:0] dest, input logic [3:0] src,
                               input logic ri, input logic [15:0] immv);
    bus.opCode      = op;
    bus.enableRegs  = en;
    bus.resRegs     = res;
    bus.enableFlags = ef;
    bus.muxRdest    = dest;
    bus.muxRsrc     = src;
    bus.muxRI       = ri;
    bus.imm         = immv;
    @(posedge clk);
    #1;
  endtask

  // Read a register through the read port using a NOP cycle
  task automatic readReg(input logic [3:0] sel, output logic [15:0] value);
    bus.rd_sel = sel;
    applyStimulus(OP_NOP, 16'h0, 16'h0, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    value = bus.rd_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    applyStimulus(OP_MOV, 16'h00F0, 16'h0, 5'h1F, 4'd0, 4'd0, 1'b1, 16'h8000);
    applyStimulus(OP_MOV, 16'h0F00, 16'h0, 5'h00, 4'd0, 4'd0, 1'b1, 16'h1234);
    bus.rd_sel = 4'd4;
    applyStimulus(8'hFF, 16'hFFFF, 16'h0, 5'h1F, 4'd0, 4'd0, 1'b0, 16'h0);
    rs = 1'b1;
    applyStimulus(8'hFF, 16'hFFFF, 16'h0, 5'h1F, 4'd0, 4'd0, 1'b1, 16'h5555);
    rs = 1'b0;
    checks++;
    if (bus.flags !== 5'h00) begin
      failures++;
      $display("[TB] FAIL reset_flags got %h want %h", bus.flags, 5'h00);
    end
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_illegal got %b want 0", bus.illegal_op);
    end
    checks++;
    if (bus.rd_data !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_rd_data got %h want 0000", bus.rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      readReg(4'(i), v);
      checks++;
      if (v !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL reset_R%0d got %h want 0000", i, v);
      end
    end
  endtask

  task automatic test_fibonacci();
    logic [15:0] v;
    logic [15:0] fib [16];
    fib[0] = 16'd0;
    fib[1] = 16'd1;
    for (int k = 2; k < 16; k++) fib[k] = fib[k-1] + fib[k-2];
    applyStimulus(OP_NOP, 16'h0, 16'hFFFF, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    applyStimulus(OP_MOV, 16'h0002, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'h0001);
    for (int k = 2; k < 16; k++) begin
      applyStimulus(OP_ADD, 16'(1 << k), 16'h0, 5'h0, 4'(k - 1), 4'(k - 2),
                    1'b0, 16'h0);
    end
    for (int i = 0; i < 16; i++) begin
      readReg(4'(i), v);
      checks++;
      if (v !== fib[i]) begin
        failures++;
        $display("[TB] FAIL fib_R%0d got %0d want %0d", i, v, fib[i]);
      end
    end
    readReg(4'd15, v);
    checks++;
    if (v !== 16'd610) begin
      failures++;
      $display("[TB] FAIL fib_R15_610 got %0d want 610", v);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    // CMP 0 vs 1 with only L enabled: L=1, everything else stays 0
    applyStimulus(OP_NOP, 16'h0, 16'h0003, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    applyStimulus(OP_CMP, 16'h0, 16'h0, 5'h02, 4'd0, 4'd0, 1'b1, 16'h0001);
    checks++;
    if (bus.flags !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL cmp_L_only got %b want 00010", bus.flags);
    end
    applyStimulus(OP_MOV, 16'h0001, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'h7FFF);
    applyStimulus(OP_MOV, 16'h0002, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'h0001);
    applyStimulus(OP_ADD, 16'h0004, 16'h0, 5'h1F, 4'd0, 4'd1, 1'b0, 16'h0);
    checks++;
    if (bus.flags !== 5'b10110) begin
      failures++;
      $display("[TB] FAIL overflow_flags got %b want 10110", bus.flags);
    end
    readReg(4'd2, v);
    checks++;
    if (v !== 16'h8000) begin
      failures++;
      $display("[TB] FAIL overflow_R2 got %h want 8000", v);
    end
  endtask

  task automatic test_borrow_chain();
    logic [15:0] v;
    applyStimulus(OP_NOP, 16'h0, 16'h0001, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    applyStimulus(OP_SUB, 16'h0001, 16'h0, 5'h1F, 4'd0, 4'd0, 1'b1, 16'h0001);
    checks++;
    if (bus.flags !== 5'b10011) begin
      failures++;
      $display("[TB] FAIL sub_flags got %b want 10011", bus.flags);
    end
    readReg(4'd0, v);
    checks++;
    if (v !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sub_R0 got %h want FFFF", v);
    end
    applyStimulus(OP_SUBC, 16'h0001, 16'h0, 5'h1F, 4'd0, 4'd0, 1'b1, 16'h0000);
    checks++;
    if (bus.flags !== 5'b10010) begin
      failures++;
      $display("[TB] FAIL subc_flags got %b want 10010", bus.flags);
    end
    readReg(4'd0, v);
    checks++;
    if (v !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL subc_R0 got %h want FFFE", v);
    end
  endtask

  task automatic test_cmp_priority();
    logic [15:0] v;
    applyStimulus(OP_MOV, 16'h0008, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'h0003);
    applyStimulus(OP_MOV, 16'h0010, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'hFFFF);
    applyStimulus(OP_CMP, 16'hFFFF, 16'h0, 5'h1F, 4'd3, 4'd4, 1'b0, 16'h0);
    checks++;
    if (bus.flags !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL cmp_flags got %b want 00010", bus.flags);
    end
    readReg(4'd3, v);
    checks++;
    if (v !== 16'h0003) begin
      failures++;
      $display("[TB] FAIL cmp_R3_hold got %h want 0003", v);
    end
    readReg(4'd0, v);
    checks++;
    if (v !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL cmp_R0_hold got %h want FFFE", v);
    end
    // R2 has both clear and enable; R5 only enable; 3 + FFFF = 0002
    applyStimulus(OP_ADD, 16'h0024, 16'h0004, 5'h0, 4'd3, 4'd4, 1'b0, 16'h0);
    readReg(4'd2, v);
    checks++;
    if (v !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL clear_priority_R2 got %h want 0000", v);
    end
    readReg(4'd5, v);
    checks++;
    if (v !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL add_R5 got %h want 0002", v);
    end
  endtask

  task automatic test_illegal_hold();
    logic [15:0] v;
    applyStimulus(8'hFF, 16'hFFFF, 16'h0, 5'h1F, 4'd0, 4'd1, 1'b1, 16'h1234);
    checks++;
    if (bus.illegal_op !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_pulse got %b want 1", bus.illegal_op);
    end
    checks++;
    if (bus.flags !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL illegal_flags got %b want 00010", bus.flags);
    end
    readReg(4'd5, v);
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++;
      $display("[TB] FAIL illegal_one_cycle got %b want 0", bus.illegal_op);
    end
    checks++;
    if (v !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL illegal_R5_hold got %h want 0002", v);
    end
    readReg(4'd15, v);
    checks++;
    if (v !== 16'd610) begin
      failures++;
      $display("[TB] FAIL illegal_R15_hold got %0d want 610", v);
    end
    // FFFE + FFFE would set C and N, but no flag is enabled
    applyStimulus(OP_ADD, 16'h0040, 16'h0, 5'h00, 4'd0, 4'd0, 1'b0, 16'h0);
    checks++;
    if (bus.flags !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL noflag_enable got %b want 00010", bus.flags);
    end
    readReg(4'd6, v);
    checks++;
    if (v !== 16'hFFFC) begin
      failures++;
      $display("[TB] FAIL noflag_R6 got %h want FFFC", v);
    end
  endtask

  task automatic test_logic_addc();
    logic [15:0] v;
    applyStimulus(OP_MOV, 16'h0100, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'h0F0F);
    applyStimulus(OP_AND, 16'h0200, 16'h0, 5'h0, 4'd8, 4'd0, 1'b1, 16'h00FF);
    applyStimulus(OP_OR,  16'h0400, 16'h0, 5'h0, 4'd8, 4'd0, 1'b1, 16'h00FF);
    applyStimulus(OP_XOR, 16'h0800, 16'h0, 5'h1F, 4'd8, 4'd0, 1'b1, 16'h0F0F);
    checks++;
    if (bus.flags !== 5'b01010) begin
      failures++;
      $display("[TB] FAIL xor_flags got %b want 01010", bus.flags);
    end
    readReg(4'd9, v);
    checks++;
    if (v !== 16'h000F) begin
      failures++;
      $display("[TB] FAIL and_R9 got %h want 000F", v);
    end
    readReg(4'd10, v);
    checks++;
    if (v !== 16'h0FFF) begin
      failures++;
      $display("[TB] FAIL or_R10 got %h want 0FFF", v);
    end
    applyStimulus(OP_MOV, 16'h1000, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'hFFFF);
    applyStimulus(OP_ADD, 16'h2000, 16'h0, 5'h1F, 4'd12, 4'd0, 1'b1, 16'h0001);
    checks++;
    if (bus.flags !== 5'b01011) begin
      failures++;
      $display("[TB] FAIL add_carry_flags got %b want 01011", bus.flags);
    end
    applyStimulus(OP_ADDC, 16'h4000, 16'h0, 5'h1F, 4'd8, 4'd0, 1'b1, 16'h0001);
    checks++;
    if (bus.flags !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL addc_flags got %b want 00010", bus.flags);
    end
    readReg(4'd14, v);
    checks++;
    if (v !== 16'h0F11) begin
      failures++;
      $display("[TB] FAIL addc_R14 got %h want 0F11", v);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(OP_MOV, 16'h0080, 16'h0, 5'h0, 4'd0, 4'd0, 1'b1, 16'h0005);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(OP_ADD, 16'h0080, 16'h0, 5'h0, 4'd7, 4'd7, 1'b0, 16'h0);
    end
    // Read port sees R7 before this edge's write, then the new value
    bus.rd_sel = 4'd7;
    applyStimulus(OP_ADD, 16'h0080, 16'h0, 5'h0, 4'd7, 4'd7, 1'b0, 16'h0);
    checks++;
    if (bus.rd_data !== 16'd40) begin
      failures++;
      $display("[TB] FAIL b2b_old_value got %0d want 40", bus.rd_data);
    end
    applyStimulus(OP_NOP, 16'h0, 16'h0, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    checks++;
    if (bus.rd_data !== 16'd80) begin
      failures++;
      $display("[TB] FAIL b2b_new_value got %0d want 80", bus.rd_data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rs       = 1'b1;
    bus.rd_sel = 4'd0;
    applyStimulus(OP_NOP, 16'h0, 16'h0, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    applyStimulus(OP_NOP, 16'h0, 16'h0, 5'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    rs = 1'b0;
    test_reset();
    test_fibonacci();
    test_overflow();
    test_borrow_chain();
    test_cmp_priority();
    test_illegal_hold();
    test_logic_addc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
